// File: rtl/adventure_pkg.sv
// Shared types for the adventure room controller: room encoding and move directions.
package adventure_pkg;

    localparam int unsigned NUM_ROOMS = 7;

    typedef enum logic [2:0] {
        RoomCave         = 3'd0,
        RoomTunnel       = 3'd1,
        RoomRiver        = 3'd2,
        RoomSwordStash   = 3'd3,
        RoomDragonDen    = 3'd4,
        RoomVictoryVault = 3'd5,
        RoomGraveyard    = 3'd6
    } room_t;

    typedef enum logic [1:0] {
        DirN = 2'd0,
        DirS = 2'd1,
        DirE = 2'd2,
        DirW = 2'd3
    } dir_t;

endpackage

// File: rtl/dir_strobe.sv
// One-hot validation and rising-edge detection of the debounced direction buttons.
module dir_strobe
    import adventure_pkg::*;
(
    input  logic clk,
    input  logic reset,
    input  logic n,
    input  logic s,
    input  logic e,
    input  logic w,
    output logic go,
    output dir_t dir
);

    logic held_q;
    logic any_dir;
    logic one_hot;

    assign any_dir = n | s | e | w;
    assign one_hot = ({2'b00, n} + {2'b00, s} + {2'b00, e} + {2'b00, w}) == 3'd1;

    // Multi-hot still counts as held, so it masks the next single-button press.
    always_ff @(posedge clk) begin
        if (reset) begin
            held_q <= 1'b0;
        end else begin
            held_q <= any_dir;
        end
    end

    always_comb begin
        go  = one_hot & ~held_q;
        dir = DirN;
        if (s) dir = DirS;
        if (e) dir = DirE;
        if (w) dir = DirW;
    end

endmodule

// File: rtl/adventure_room_ctrl.sv
// Room-sequencing controller: room register, saturating move counter and output decode.
module adventure_room_ctrl
    import adventure_pkg::*;
#(
    parameter int unsigned MOVE_W = 8
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              n,
    input  logic              s,
    input  logic              e,
    input  logic              w,
    input  logic              v,
    output logic              in_secret_sword_stash,
    output logic [2:0]        room,
    output logic [6:0]        room_lights,
    output logic              win,
    output logic              dead,
    output logic [MOVE_W-1:0] moves
);

    logic              go;
    dir_t              dir;
    room_t             room_q, room_d;
    logic              move_ok;
    logic [MOVE_W-1:0] moves_q, moves_d;

    dir_strobe u_dir_strobe (
        .clk   (clk),
        .reset (reset),
        .n     (n),
        .s     (s),
        .e     (e),
        .w     (w),
        .go    (go),
        .dir   (dir)
    );

    always_comb begin
        room_d  = room_q;
        move_ok = 1'b0;
        case (room_q)
            RoomCave: begin
                if (go && dir == DirE) begin
                    room_d  = RoomTunnel;
                    move_ok = 1'b1;
                end
            end
            RoomTunnel: begin
                if (go && dir == DirS) begin
                    room_d  = RoomRiver;
                    move_ok = 1'b1;
                end else if (go && dir == DirW) begin
                    room_d  = RoomCave;
                    move_ok = 1'b1;
                end
            end
            RoomRiver: begin
                if (go && dir == DirN) begin
                    room_d  = RoomTunnel;
                    move_ok = 1'b1;
                end else if (go && dir == DirW) begin
                    room_d  = RoomSwordStash;
                    move_ok = 1'b1;
                end else if (go && dir == DirE) begin
                    room_d  = RoomDragonDen;
                    move_ok = 1'b1;
                end
            end
            RoomSwordStash: begin
                if (go && dir == DirE) begin
                    room_d  = RoomRiver;
                    move_ok = 1'b1;
                end
            end
            // Den resolves on its own; that exit is not a player move.
            RoomDragonDen:    room_d = v ? RoomVictoryVault : RoomGraveyard;
            RoomVictoryVault: room_d = RoomVictoryVault;
            RoomGraveyard:    room_d = RoomGraveyard;
            default:          room_d = RoomCave;
        endcase
    end

    always_comb begin
        moves_d = moves_q;
        if (move_ok && moves_q != {MOVE_W{1'b1}}) begin
            moves_d = moves_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            room_q  <= RoomCave;
            moves_q <= '0;
        end else begin
            room_q  <= room_d;
            moves_q <= moves_d;
        end
    end

    always_comb begin
        room                  = room_q;
        room_lights           = 7'b0000001 << room_q;
        in_secret_sword_stash = room_q == RoomSwordStash;
        win                   = room_q == RoomVictoryVault;
        dead                  = room_q == RoomGraveyard;
        moves                 = moves_q;
    end

endmodule

// File: tb/tb_adventure_room_ctrl.sv
// Directed bench for adventure_room_ctrl with a behavioural sword register alongside.
module tb_adventure_room_ctrl;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       n = 1'b0, s = 1'b0, e = 1'b0, w = 1'b0;
    logic       v, v2;
    logic       stash, stash2;
    logic [2:0] room, room2;
    logic [6:0] lights, lights2;
    logic       win, win2, dead, dead2;
    logic [7:0] moves;
    logic [1:0] moves2;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    adventure_room_ctrl #(.MOVE_W(8)) dut (
        .clk                   (clk),
        .reset                 (reset),
        .n                     (n),
        .s                     (s),
        .e                     (e),
        .w                     (w),
        .v                     (v),
        .in_secret_sword_stash (stash),
        .room                  (room),
        .room_lights           (lights),
        .win                   (win),
        .dead                  (dead),
        .moves                 (moves)
    );

    adventure_room_ctrl #(.MOVE_W(2)) dut2 (
        .clk                   (clk),
        .reset                 (reset),
        .n                     (n),
        .s                     (s),
        .e                     (e),
        .w                     (w),
        .v                     (v2),
        .in_secret_sword_stash (stash2),
        .room                  (room2),
        .room_lights           (lights2),
        .win                   (win2),
        .dead                  (dead2),
        .moves                 (moves2)
    );

    // Sword register: set one edge after the stash is entered, cleared by reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            v  <= 1'b0;
            v2 <= 1'b0;
        end else begin
            if (stash)  v  <= 1'b1;
            if (stash2) v2 <= 1'b1;
        end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic step(input int cycles = 1);
        for (int i = 0; i < cycles; i++) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic set_dir(input logic [3:0] nsew);
        {n, s, e, w} = nsew;
    endtask

    // One press sampled at one edge, then one released cycle.
    task automatic pulse(input logic [3:0] nsew);
        set_dir(nsew);
        step();
        set_dir(4'b0000);
        step();
    endtask

    task automatic do_reset();
        set_dir(4'b0000);
        reset = 1'b1;
        step(2);
        reset = 1'b0;
        step();
    endtask

    localparam logic [3:0] PN = 4'b1000;
    localparam logic [3:0] PS = 4'b0100;
    localparam logic [3:0] PE = 4'b0010;
    localparam logic [3:0] PW = 4'b0001;

    initial begin
        // Reset and idle
        reset = 1'b1;
        step(2);
        reset = 1'b0;
        step(5);
        check("rst_room", room, 0);
        check("rst_lights", lights, 7'b0000001);
        check("rst_moves", moves, 0);
        check("rst_win", win, 0);
        check("rst_dead", dead, 0);
        check("rst_stash", stash, 0);

        // Swordless path to the den
        pulse(PE);
        check("p1_tunnel", room, 1);
        check("p1_lights", lights, 7'b0000010);
        pulse(PS);
        check("p1_river", room, 2);
        set_dir(PE);
        step();
        check("p1_den", room, 4);
        check("p1_den_lights", lights, 7'b0010000);
        set_dir(4'b0000);
        step();
        check("p1_grave", room, 6);
        check("p1_dead", dead, 1);
        check("p1_win", win, 0);
        check("p1_moves", moves, 3);
        pulse(PE);
        pulse(PN);
        pulse(PW);
        check("p1_grave_abs", room, 6);
        check("p1_moves_frozen", moves, 3);

        // Sword path
        do_reset();
        check("p2_v_cleared", v, 0);
        pulse(PE);
        pulse(PS);
        set_dir(PW);
        step();
        check("p2_stash_room", room, 3);
        check("p2_stash_flag", stash, 1);
        check("p2_v_not_yet", v, 0);
        set_dir(4'b0000);
        step();
        check("p2_v_set", v, 1);
        pulse(PN);
        check("p2_stash_n_ignored", room, 3);
        check("p2_stash_n_moves", moves, 3);
        pulse(PE);
        check("p2_back_river", room, 2);
        check("p2_stash_left", stash, 0);
        set_dir(PE);
        step();
        check("p2_den", room, 4);
        set_dir(4'b0000);
        step();
        check("p2_vault", room, 5);
        check("p2_win", win, 1);
        check("p2_dead", dead, 0);
        check("p2_moves", moves, 5);
        pulse(PW);
        check("p2_vault_abs", room, 5);

        // Held button and multi-hot
        do_reset();
        set_dir(PE);
        step(10);
        check("p3_hold_room", room, 1);
        check("p3_hold_moves", moves, 1);
        set_dir(4'b0000);
        step();
        set_dir(PE | PS);
        step(2);
        check("p3_multi_room", room, 1);
        check("p3_multi_moves", moves, 1);
        set_dir(4'b0000);
        step();
        pulse(PW);
        check("p3_tunnel_w", room, 0);
        pulse(PW);
        check("p3_cave_w_room", room, 0);
        check("p3_cave_w_moves", moves, 2);

        // Saturation on the narrow instance
        do_reset();
        for (int i = 0; i < 6; i++) begin
            pulse(PE);
            pulse(PW);
            if (i == 0) check("p4_narrow_2", moves2, 2);
        end
        check("p4_wide_moves", moves, 12);
        check("p4_narrow_sat", moves2, 3);
        check("p4_room", room2, 0);

        // Mid-game reset wins over a simultaneous move
        pulse(PE);
        pulse(PS);
        pulse(PW);
        step();
        check("p5_stash_v", v, 1);
        reset = 1'b1;
        set_dir(PE);
        step();
        check("p5_rst_room", room, 0);
        check("p5_rst_moves", moves, 0);
        check("p5_rst_moves2", moves2, 0);
        check("p5_rst_v", v, 0);
        reset = 1'b0;
        set_dir(4'b0000);
        step(2);
        check("p5_after_room", room, 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
